// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer for the RV32IF core
module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [31:0]      instr,
  input  logic [31:0]      imm,
  input  logic [31:0]      alu_result,
  input  logic             branch_taken,
  output logic             fpu_start,
  input  logic             fpu_done,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             frf_we,
  output logic [31:0]      pc,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    EXEC       = 3'd3,
    EXEC_WAIT  = 3'd4,
    MEM        = 3'd5,
    WB         = 3'd6,
    SPARE      = 3'd7
  } state_t;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_CI = 7'b0010011, OP_CR = 7'b0110011,
                         OP_FLD = 7'b0000111, OP_FST = 7'b0100111, OP_F = 7'b1010011;
  state_t      cur, nxt;
  logic        armed;
  logic [6:0]  op, f7;
  logic        is_f, is_st, is_mem, f_int, int_wr, jump_imm;
  logic [31:0] pc_nxt;
  assign op = instr[6:0];
  assign f7 = instr[31:25];
  always_comb begin
    is_f     = op == OP_F;
    is_st    = op == OP_ST || op == OP_FST;
    is_mem   = is_st || op == OP_LD || op == OP_FLD;
    f_int    = is_f && (f7 == 7'b1010000 || f7 == 7'b1110000 || f7 == 7'b1100000);
    int_wr   = (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_CI, OP_CR}) || f_int;
    jump_imm = op == OP_JAL || (op == OP_BR && branch_taken);
    pc_nxt   = jump_imm ? pc + imm : op == OP_JALR ? alu_result & ~32'h1 : pc + 32'd4;
  end
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:      nxt = armed ? FETCH_WAIT : FETCH;
      FETCH_WAIT: nxt = imem_valid ? DECODE : FETCH_WAIT;
      DECODE:     nxt = EXEC;
      EXEC:       nxt = is_f ? EXEC_WAIT : is_mem ? MEM : WB;
      EXEC_WAIT:  nxt = fpu_done ? WB : EXEC_WAIT;
      MEM:        nxt = dmem_ready ? WB : MEM;
      default:    nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur     <= FETCH;
      armed   <= 1'b0;
      pc      <= RESET_PC;
      instr   <= '0;
      instret <= '0;
    end else begin
      cur   <= nxt;
      armed <= 1'b1;
      if (cur == FETCH_WAIT && imem_valid) instr <= imem_rdata;
      if (cur == WB) begin
        pc      <= pc_nxt;
        instret <= instret + CNT_W'(1);
      end
    end
  end
  assign imem_req  = cur == FETCH && armed;
  assign imem_addr = pc;
  assign fpu_start = cur == EXEC && is_f;
  assign dmem_req  = cur == MEM;
  assign dmem_we   = dmem_req && is_st;
  assign rf_we     = cur == WB && int_wr && instr[11:7] != 5'd0;
  assign frf_we    = cur == WB && (op == OP_FLD || (is_f && !f_int));
  assign state     = cur;
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed and randomized instruction-level check of core_seq_ctrl against a reference model
module tb_core_seq_ctrl;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67, BR = 7'h63,
                         LD = 7'h03, ST = 7'h23, CI = 7'h13, CR = 7'h33, FLD = 7'h07,
                         FST = 7'h27, FOP = 7'h53;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        imem_req, imem_valid, branch_taken, fpu_start, fpu_done;
  logic        dmem_req, dmem_we, dmem_ready, rf_we, frf_we;
  logic [31:0] imem_addr, imem_rdata, instr, imm, alu_result, pc;
  logic [2:0]  state;
  logic [3:0]  instret;
  int          checks = 0, failures = 0;
  logic [31:0] m_pc = 32'h100;
  logic [3:0]  m_ret = 4'd0;
  core_seq_ctrl #(.RESET_PC(32'h100), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instr(instr), .imm(imm),
    .alu_result(alu_result), .branch_taken(branch_taken), .fpu_start(fpu_start),
    .fpu_done(fpu_done), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .frf_we(frf_we), .pc(pc), .state(state), .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [31:0] w, input logic [31:0] im, input logic [31:0] alu,
                     input bit bt, input int il, input int ml, input int fl, input bit spur);
    logic [6:0]  op, f7;
    logic [31:0] e_pc;
    bit          fp, fint, mem, st, e_rf, e_frf;
    int          e_cyc, cyc, nim, nrf, nfrf, nfs, ndq, nwe_bad, rf_at, frf_at, fs_at;
    op    = w[6:0];
    f7    = w[31:25];
    fp    = op == FOP;
    fint  = fp && (f7 inside {7'h50, 7'h70, 7'h60});
    mem   = op inside {LD, ST, FLD, FST};
    st    = op inside {ST, FST};
    e_rf  = ((op inside {LUI, AUIPC, JAL, JALR, LD, CI, CR}) || fint) && w[11:7] != 5'd0;
    e_frf = op == FLD || (fp && !fint);
    e_cyc = 5 + il + (mem ? ml + 1 : 0) + (fp ? fl : 0);
    e_pc  = (op == JAL || (op == BR && bt)) ? m_pc + im : op == JALR ? alu & ~32'h1 : m_pc + 32'd4;
    imm = im;
    alu_result = alu;
    chk("fetch_addr", imem_addr, m_pc);
    nim = 0; nrf = 0; nfrf = 0; nfs = 0; ndq = 0; nwe_bad = 0; rf_at = -1; frf_at = -1; fs_at = -1;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0 && imem_req) break;
      if (imem_req) nim++;
      if (rf_we) begin nrf++; rf_at = cyc; end
      if (frf_we) begin nfrf++; frf_at = cyc; end
      if (fpu_start) begin nfs++; fs_at = cyc; end
      if (dmem_req) begin ndq++; if (dmem_we !== st) nwe_bad++; end
      imem_valid   = (cyc >= 1 && cyc <= 1 + il) ? (cyc == 1 + il) : 1'($urandom_range(0, 1));
      imem_rdata   = (cyc == 1 + il) ? w : $urandom();
      dmem_ready   = dmem_req ? (ndq == ml + 1) : 1'($urandom_range(0, 1));
      fpu_done     = fpu_start ? (spur | 1'($urandom_range(0, 1))) :
                     (fs_at >= 0 && cyc > fs_at && cyc <= fs_at + fl) ? (cyc == fs_at + fl) :
                     1'($urandom_range(0, 1));
      branch_taken = (state == 3'd6) ? bt : !bt;
      @(posedge clk); #1;
    end
    chk("cycles", cyc, e_cyc);
    chk("imem_req_pulses", nim, 1);
    chk("fpu_start_pulses", nfs, fp);
    chk("dmem_req_cycles", ndq, mem ? ml + 1 : 0);
    chk("dmem_we_unstable", nwe_bad, 0);
    chk("rf_we_pulses", nrf, e_rf);
    chk("rf_we_cycle", rf_at, e_rf ? e_cyc - 1 : -1);
    chk("frf_we_pulses", nfrf, e_frf);
    chk("frf_we_cycle", frf_at, e_frf ? e_cyc - 1 : -1);
    chk("instr", instr, w);
    chk("state_fetch", state, 0);
    m_pc  = e_pc;
    m_ret = m_ret + 4'd1;
    chk("pc", pc, m_pc);
    chk("instret", instret, m_ret);
  endtask
  task automatic run_rand();
    logic [6:0]  ops [13] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, CI, CR, FLD, FST, FOP, 7'h7f};
    logic [6:0]  f7s [3] = '{7'h50, 7'h70, 7'h60};
    logic [31:0] r;
    logic [6:0]  op;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 13);
    op = (k == 13) ? 7'($urandom()) : ops[k];
    r[6:0] = op;
    if (op == FOP && $urandom_range(0, 1) == 1) r[31:25] = f7s[$urandom_range(0, 2)];
    if ($urandom_range(0, 4) == 0) r[11:7] = 5'd0;
    run(r, $urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
        $urandom_range(0, 3), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
  endtask
  initial begin
    imem_valid = 0; imem_rdata = 0; imm = 0; alu_result = 0;
    branch_taken = 0; fpu_done = 0; dmem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc", pc, 32'h100);
    rstn = 1;
    chk("rel_imem_req", imem_req, 0);
    @(posedge clk); #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h100);
    imem_valid = 1;
    imem_rdata = 32'h0000a083;
    for (int i = 0; i < 20 && !dmem_req; i++) begin @(posedge clk); #1; end
    imem_valid = 0;
    chk("reach_mem", dmem_req, 1);
    repeat (2) begin @(posedge clk); #1; end
    #3 rstn = 0;
    #1;
    chk("midmem_state", state, 0);
    chk("midmem_dmem_req", dmem_req, 0);
    chk("midmem_pc", pc, 32'h100);
    chk("midmem_instret", instret, 0);
    chk("midmem_instr", instr, 0);
    dmem_ready = 1; fpu_done = 1; imem_valid = 1;
    @(posedge clk); #1;
    rstn = 1; dmem_ready = 0; fpu_done = 0; imem_valid = 0;
    chk("rel2_state", state, 0);
    chk("rel2_imem_req", imem_req, 0);
    @(posedge clk); #1;
    chk("rel2_first_req", imem_req, 1);
    chk("rel2_first_addr", imem_addr, 32'h100);
    run(32'h00500093, 32'd5, 32'd5, 0, 0, 0, 1, 0);
    run(32'h00500013, 32'd5, 32'd5, 0, 0, 0, 1, 0);
    run(32'h0020a023, 32'd0, 32'h40, 0, 0, 3, 1, 0);
    run(32'h000000ef, 32'h200 - m_pc, 32'd0, 0, 0, 0, 1, 0);
    run(32'hfe000ce3, 32'hffff_fff8, 32'd0, 1, 0, 0, 1, 0);
    chk("beq_taken_pc", pc, 32'h1f8);
    run(32'h000000ef, 32'h200 - m_pc, 32'd0, 0, 1, 0, 1, 0);
    run(32'hfe000ce3, 32'hffff_fff8, 32'd0, 0, 0, 0, 1, 0);
    chk("beq_not_taken_pc", pc, 32'h204);
    run(32'h000080e7, 32'd0, 32'h301, 0, 0, 0, 1, 0);
    chk("jalr_pc", pc, 32'h300);
    run(32'h003100d3, 32'd0, 32'd0, 0, 0, 0, 4, 1);
    run(32'ha020a0d3, 32'd0, 32'd0, 0, 0, 0, 2, 1);
    run(32'h00000fff, 32'h40, 32'h40, 1, 0, 0, 1, 0);
    for (int i = 0; i < 45; i++) run_rand();
    for (int i = 0; i < 16 && m_ret != 4'hf; i++) run(32'h00100093, 32'd1, 32'd1, 0, 0, 0, 1, 0);
    chk("instret_full", instret, 4'hf);
    run(32'h00100093, 32'd1, 32'd1, 0, 0, 0, 1, 0);
    chk("instret_wrap", instret, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
